// File: rtl/divider_scheduler.sv
`timescale 1ns/1ps
// Round-robin front end that shares one fixed-latency iterative divider among NREQ clients.
// Sequences start/wait/capture and returns each result with a one-cycle ack to the grantee.
module divider_scheduler #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned LATENCY = 17
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   dividend_in,
   input  logic [7*NREQ-1:0]   divisor_in,
   output logic [NREQ-1:0]     ack,
   output logic [7:0]          quotient_out,
   output logic [6:0]          remainder_out,
   output logic                err,
   output logic                busy,
   output logic                div_start,
   output logic [7:0]          div_dividend,
   output logic [6:0]          div_divisor,
   input  logic [7:0]          div_quotient,
   input  logic [6:0]          div_remainder,
   input  logic                div_valid
);

   localparam int unsigned DW   = 8;
   localparam int unsigned VW   = 7;
   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNTW = $clog2(LATENCY + 1);
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDXW-1:0]   r_ptr;
   logic [CNTW-1:0]   r_cnt;
   logic [NREQ-1:0]   r_ack;
   logic [DW-1:0]     r_quotient;
   logic [VW-1:0]     r_remainder;
   logic              r_err;
   logic              r_busy;
   logic              r_start;
   logic [DW-1:0]     r_dividend;
   logic [VW-1:0]     r_divisor;

   logic              w_gnt_found;
   logic [IDXW-1:0]   w_gnt_idx;
   logic [IDXW-1:0]   w_cand;
   logic [DW-1:0]     w_sel_dividend;
   logic [VW-1:0]     w_sel_divisor;

   // First set request searching upward from pointer+1 with wrap.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         w_cand = IDXW'((32'(r_ptr) + i) % NREQ);
         if (!w_gnt_found && req[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_sel_dividend = '0;
      w_sel_divisor  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == IDXW'(i)) begin
            w_sel_dividend = dividend_in[DW*i +: DW];
            w_sel_divisor  = divisor_in[VW*i +: VW];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_gnt_found) w_state_nxt = (w_sel_divisor == '0) ? S_DONE : S_START;
         S_START: w_state_nxt = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; a zero divisor short-circuits straight to the ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= IDXW'(NREQ - 1);
         r_cnt       <= '0;
         r_ack       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_start     <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
      end else begin
         r_ack   <= '0;
         r_start <= (w_state_nxt == S_START);
         r_busy  <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_gnt_found) begin
                  r_ptr      <= w_gnt_idx;
                  r_dividend <= w_sel_dividend;
                  r_divisor  <= w_sel_divisor;
                  if (w_sel_divisor == '0) begin
                     r_quotient  <= 8'hFF;
                     r_remainder <= 7'h00;
                     r_err       <= 1'b1;
                     r_ack       <= ONE_HOT0 << w_gnt_idx;
                  end
               end
            end
            S_START: r_cnt <= CNTW'(LATENCY - 1);
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_quotient  <= div_quotient;
                  r_remainder <= div_remainder;
                  r_err       <= ~div_valid;
                  r_ack       <= ONE_HOT0 << r_ptr;
               end else begin
                  r_cnt <= r_cnt - CNTW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign ack           = r_ack;
   assign quotient_out  = r_quotient;
   assign remainder_out = r_remainder;
   assign err           = r_err;
   assign busy          = r_busy;
   assign div_start     = r_start;
   assign div_dividend  = r_dividend;
   assign div_divisor   = r_divisor;

endmodule

// File: tb/tb_divider_scheduler.sv
`timescale 1ns/1ps
// Directed bench for divider_scheduler with a fixed-latency divider model.
module tb_divider_scheduler;

   localparam int unsigned NREQ = 4;
   localparam int unsigned LAT  = 17;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [8*NREQ-1:0] dividend_in = '0;
   logic [7*NREQ-1:0] divisor_in = '0;
   logic [NREQ-1:0]   ack;
   logic [7:0]        quotient_out;
   logic [6:0]        remainder_out;
   logic              err;
   logic              busy;
   logic              div_start;
   logic [7:0]        div_dividend;
   logic [6:0]        div_divisor;
   logic [7:0]        div_quotient = '0;
   logic [6:0]        div_remainder = '0;
   logic              div_valid = 1'b0;
   bit                m_hold_invalid = 1'b0;
   int                m_cnt = 0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc = 0;
   int unsigned start_total = 0;
   int unsigned ack_total = 0;

   divider_scheduler #(.NREQ(NREQ), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .dividend_in(dividend_in), .divisor_in(divisor_in),
      .ack(ack), .quotient_out(quotient_out), .remainder_out(remainder_out), .err(err),
      .busy(busy), .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_valid(div_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (div_start) start_total <= start_total + 1;
      if (ack != '0) ack_total <= ack_total + 1;
   end

   // Divider model: result and valid appear LAT-1 edges after start is seen, held until next start.
   always @(posedge clk) begin
      if (div_start) begin
         m_cnt     <= LAT - 1;
         div_valid <= 1'b0;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            div_valid <= !m_hold_invalid;
            if (div_divisor != '0) begin
               div_quotient  <= div_dividend / {1'b0, div_divisor};
               div_remainder <= 7'(div_dividend % {1'b0, div_divisor});
            end
         end
      end
   end

   typedef struct {
      int unsigned idx;
      int unsigned dvd;
      int unsigned dvs;
      bit          hold_inv;
      int unsigned eq;
      int unsigned er;
      int unsigned eerr;
      int unsigned elat;
      int unsigned estarts;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input int unsigned idx, dvd, dvs, input bit hold,
                               input int unsigned eq, er, eerr, elat, estarts);
      vec_t v;
      v.idx = idx; v.dvd = dvd; v.dvs = dvs; v.hold_inv = hold;
      v.eq = eq; v.er = er; v.eerr = eerr; v.elat = elat; v.estarts = estarts;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_ops(input int unsigned idx, input int unsigned dvd, input int unsigned dvs);
      dividend_in[8*idx +: 8] = 8'(dvd);
      divisor_in[7*idx +: 7]  = 7'(dvs);
   endtask

   task automatic wait_ack(output logic [NREQ-1:0] a, output int unsigned c, output bit got);
      got = 1'b0;
      a   = '0;
      c   = 0;
      for (int n = 0; n < 80 && !got; n++) begin
         @(negedge clk);
         if (ack != '0) begin
            got = 1'b1;
            a   = ack;
            c   = cyc;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      #2;
      check("rst_ack", 32'(ack), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_start", 32'(div_start), 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_one(input vec_t v, input string tag);
      int unsigned      c0, s0, c;
      logic [NREQ-1:0]  a;
      logic [7:0]       q;
      bit               got;
      @(negedge clk);
      m_hold_invalid = v.hold_inv;
      set_ops(v.idx, v.dvd, v.dvs);
      req = NREQ'(1) << v.idx;
      c0  = cyc;
      s0  = start_total;
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 1);
      got = 1'b0;
      a   = '0;
      c   = 0;
      if (ack != '0) begin
         got = 1'b1; a = ack; c = cyc;
      end else begin
         wait_ack(a, c, got);
      end
      req = '0;
      if (!got) begin
         check({tag, "_ack_timeout"}, 0, 1);
      end else begin
         check({tag, "_ack"}, 32'(a), 32'(NREQ'(1) << v.idx));
         check({tag, "_lat"}, c - c0 - 1, v.elat);
         check({tag, "_q"}, 32'(quotient_out), v.eq);
         check({tag, "_r"}, 32'(remainder_out), v.er);
         check({tag, "_err"}, 32'(err), v.eerr);
         q = quotient_out;
         @(negedge clk);
         check({tag, "_ack_1cyc"}, 32'(ack), 0);
         check({tag, "_q_hold"}, 32'(quotient_out), 32'(q));
         check({tag, "_starts"}, start_total - s0, v.estarts);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] a;
      int unsigned     c, c1, a0;
      bit              got;
      int unsigned     dvd[4];
      int unsigned     dvs[4];

      vecs[0] = mk(0, 200, 7,   0, 28,  4, 0, 18, 1);
      vecs[1] = mk(1, 55,  0,   0, 255, 0, 1, 0,  0);
      vecs[2] = mk(2, 100, 10,  0, 10,  0, 0, 18, 1);
      vecs[3] = mk(3, 255, 1,   0, 255, 0, 0, 18, 1);
      vecs[4] = mk(1, 7,   100, 0, 0,   7, 0, 18, 1);
      vecs[5] = mk(2, 200, 7,   1, 28,  4, 1, 18, 1);
      vecs[6] = mk(0, 0,   0,   0, 255, 0, 1, 0,  0);
      vecs[7] = mk(3, 127, 127, 0, 1,   0, 0, 18, 1);

      #2;
      check("por_ack", 32'(ack), 0);
      check("por_busy", 32'(busy), 0);
      check("por_start", 32'(div_start), 0);
      check("por_q", 32'(quotient_out), 0);
      check("por_err", 32'(err), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_one(vecs[i], $sformatf("vec%0d", i));
      m_hold_invalid = 1'b0;

      // Two simultaneous requesters: 0 first, then 2 twenty cycles later.
      do_reset();
      @(negedge clk);
      set_ops(0, 50, 3);
      set_ops(2, 99, 9);
      req = 4'b0101;
      c = cyc;
      wait_ack(a, c1, got);
      check("pair_first_ack", 32'(a), 32'(4'b0001));
      check("pair_first_lat", c1 - c - 1, 18);
      check("pair_first_q", 32'(quotient_out), 16);
      check("pair_first_r", 32'(remainder_out), 2);
      req[0] = 1'b0;
      wait_ack(a, c, got);
      req = '0;
      check("pair_second_ack", 32'(a), 32'(4'b0100));
      check("pair_spacing", c - c1, 20);
      check("pair_second_q", 32'(quotient_out), 11);
      check("pair_second_r", 32'(remainder_out), 0);

      // All four held continuously: strict rotation 0,1,2,3,0,1.
      do_reset();
      dvd = '{200, 13, 255, 1};
      dvs = '{7, 5, 16, 1};
      @(negedge clk);
      for (int k = 0; k < 4; k++) set_ops(k, dvd[k], dvs[k]);
      req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         wait_ack(a, c, got);
         check($sformatf("rr_ack%0d", k), 32'(a), 32'(NREQ'(1) << (k % 4)));
         check($sformatf("rr_recon%0d", k),
               32'(quotient_out) * dvs[k % 4] + 32'(remainder_out), dvd[k % 4]);
         check($sformatf("rr_rem_lt%0d", k), 32'(32'(remainder_out) < dvs[k % 4]), 1);
      end
      req = '0;
      repeat (25) @(negedge clk);

      // Asynchronous reset mid-WAIT discards the operation.
      do_reset();
      @(negedge clk);
      set_ops(0, 200, 7);
      req = 4'b0001;
      repeat (7) @(posedge clk);
      #1;
      check("abort_busy_before", 32'(busy), 1);
      reset = 1'b0;
      req   = '0;
      a0    = ack_total;
      #2;
      check("abort_start", 32'(div_start), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_ack", 32'(ack), 0);
      check("abort_q", 32'(quotient_out), 0);
      #3;
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_no_ack", ack_total - a0, 0);
      run_one(mk(3, 255, 1, 0, 255, 0, 0, 18, 1), "post_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
